// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encoding and TX_status_register bit positions.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RETRY = 3'd4
  } tx_arb_state_e;

  localparam int TX_ERR_BIT   = 0;
  localparam int TX_FULL_BIT  = 1;
  localparam int TX_EMPTY_BIT = 2;

  localparam int RETRY_CNT_W  = 4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake plus UART TX write port, bundled for the arbiter.
// master: the arbiter; slave: requesters and UART side.
interface uart_tx_arb_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           drop_err;
  logic                         uart_write_data;
  logic [DATA_SIZE-1:0]         uart_bus_data_in;
  logic [7:0]                   uart_tx_status;
  logic                         busy;
  logic [GW-1:0]                grant_id;

  modport master (
    input  req_valid, req_data, uart_tx_status,
    output req_ready, drop_err, uart_write_data, uart_bus_data_in, busy, grant_id
  );

  modport slave (
    output req_valid, req_data, uart_tx_status,
    input  req_ready, drop_err, uart_write_data, uart_bus_data_in, busy, grant_id
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first active request after last_grant,
// wrapping modulo NUM_REQ.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic               any,
  output logic [GW-1:0]      winner
);

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return GW'(s);
  endfunction

  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any && req[wrap_idx(last_grant, k)]) begin
        any    = 1'b1;
        winner = wrap_idx(last_grant, k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX FIFO write port between NUM_REQ requesters: round-robin
// grant, single-cycle write pulse, error check and bounded retry.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4,
  parameter int RETRY_MAX = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_tx_arb_if.master bus
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [RETRY_CNT_W-1:0] RETRY_LAST = RETRY_CNT_W'(RETRY_MAX - 1);

  tx_arb_state_e          state, state_nxt;
  logic [GW-1:0]          grant_id, last_grant;
  logic [DATA_SIZE-1:0]   hold;
  logic [RETRY_CNT_W-1:0] retry_cnt;
  logic                   err_q;
  logic                   any;
  logic [GW-1:0]          winner;
  logic                   full;
  logic                   last_try;
  logic                   done;

  assign full     = bus.uart_tx_status[TX_FULL_BIT];
  assign last_try = (retry_cnt == RETRY_LAST);
  assign done     = (state == ST_CHECK) && (!err_q || last_try);

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .any        (any),
    .winner     (winner)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any && !full) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = done ? ST_IDLE : ST_RETRY;
      ST_RETRY: if (!full) state_nxt = ST_WRITE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Error flag is captured at the end of WAIT so that the CHECK-cycle
  // handshake pulses come from flops rather than straight from the status input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      hold       <= '0;
      retry_cnt  <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= bus.uart_tx_status[TX_ERR_BIT];
      case (state)
        ST_IDLE: if (any && !full) begin
          grant_id  <= winner;
          hold      <= bus.req_data[winner*DATA_SIZE +: DATA_SIZE];
          retry_cnt <= '0;
        end
        ST_CHECK: begin
          if (done) last_grant <= grant_id;
          else      retry_cnt  <= retry_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.uart_write_data  = (state == ST_WRITE);
  assign bus.uart_bus_data_in = hold;
  assign bus.busy             = (state != ST_IDLE);
  assign bus.grant_id         = grant_id;
  assign bus.req_ready        = done ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.drop_err         = (done && err_q) ? (NUM_REQ'(1) << grant_id) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of single transactions plus
// hand-written backpressure, retry-under-full, reset and fairness sequences.
module tb_uart_tx_arbiter;
  import uart_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NUM_REQ(4), .DATA_SIZE(8)) bus();

  uart_tx_arbiter #(.DATA_SIZE(8), .NUM_REQ(4), .RETRY_MAX(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_write"}, 32'(bus.uart_write_data), 0);
    check({tag, "_bus"},   32'(bus.uart_bus_data_in), 0);
    check({tag, "_grant"}, 32'(bus.grant_id), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_drop"},  32'(bus.drop_err), 0);
  endtask

  // err_mode: 0 never, 1 error on first attempt only, 2 error on every attempt
  task automatic run_txn(input int err_mode, input logic [7:0] exp_data, input int budget,
                         output int nwr, output int wr_at, output int bad,
                         output int rdy_at, output logic [3:0] rdy,
                         output logic [3:0] drp, output int gid);
    nwr = 0; wr_at = -1; bad = 0; rdy_at = -1; rdy = '0; drp = '0; gid = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.uart_write_data === 1'b1) begin
        nwr++;
        if (wr_at < 0) wr_at = k;
        if (bus.uart_bus_data_in !== exp_data) bad++;
        bus.uart_tx_status[TX_ERR_BIT] = (err_mode == 2) || (err_mode == 1 && nwr == 1);
      end
      if ((|bus.req_ready) === 1'b1) begin
        rdy_at = k;
        rdy = bus.req_ready;
        drp = bus.drop_err;
        gid = int'(bus.grant_id);
        bus.req_valid = bus.req_valid & ~bus.req_ready;
        bus.uart_tx_status[TX_ERR_BIT] = 1'b0;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          err_mode;
    int          exp_grant;
    logic [7:0]  exp_data;
    int          exp_nwr;
    int          exp_rdy_at;
    logic        exp_drop;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int nwr, wr_at, bad, rdy_at, gid, viol, nw;
    logic [3:0] rdy, drp, exp_rdy;
    int wr_cyc[8];
    logic [7:0] wr_dat[8];

    bus.req_valid = '0;
    bus.req_data = '0;
    bus.uart_tx_status = 8'h04;

    //              valid    data          err grant data   nwr rdy drop
    tbl[0] = '{4'b0100, 32'h00A5_0000, 0, 2, 8'hA5, 1, 3,  1'b0};
    tbl[1] = '{4'b0001, 32'h0000_0011, 0, 0, 8'h11, 1, 3,  1'b0};
    tbl[2] = '{4'b1010, 32'h3300_2200, 0, 1, 8'h22, 1, 3,  1'b0};
    tbl[3] = '{4'b1010, 32'h3300_2200, 0, 3, 8'h33, 1, 3,  1'b0};
    tbl[4] = '{4'b1111, 32'h7766_5544, 0, 0, 8'h44, 1, 3,  1'b0};
    tbl[5] = '{4'b1001, 32'h9900_0088, 0, 3, 8'h99, 1, 3,  1'b0};
    tbl[6] = '{4'b0110, 32'h00BB_AA00, 0, 1, 8'hAA, 1, 3,  1'b0};
    tbl[7] = '{4'b0001, 32'h0000_003C, 1, 0, 8'h3C, 2, 7,  1'b0};
    tbl[8] = '{4'b1000, 32'hFF00_0000, 2, 3, 8'hFF, 3, 11, 1'b1};
    tbl[9] = '{4'b1111, 32'h0403_0201, 0, 0, 8'h01, 1, 3,  1'b0};

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      bus.req_data  = tbl[i].data;
      bus.req_valid = tbl[i].valid;
      run_txn(tbl[i].err_mode, tbl[i].exp_data, 20, nwr, wr_at, bad, rdy_at, rdy, drp, gid);
      exp_rdy = 4'b0001 << tbl[i].exp_grant;
      check($sformatf("v%0d_wr_at", i), 32'(wr_at), 1);
      check($sformatf("v%0d_nwr", i), 32'(nwr), 32'(tbl[i].exp_nwr));
      check($sformatf("v%0d_data_bad", i), 32'(bad), 0);
      check($sformatf("v%0d_rdy_at", i), 32'(rdy_at), 32'(tbl[i].exp_rdy_at));
      check($sformatf("v%0d_ready", i), 32'(rdy), 32'(exp_rdy));
      check($sformatf("v%0d_drop", i), 32'(drp), tbl[i].exp_drop ? 32'(exp_rdy) : 0);
      check($sformatf("v%0d_grant", i), 32'(gid), 32'(tbl[i].exp_grant));
      bus.req_valid = '0;
      @(negedge clk);
    end

    // FIFO full in IDLE: nothing may start until full drops
    bus.uart_tx_status[TX_FULL_BIT] = 1'b1;
    bus.req_data  = 32'h0000_5A00;
    bus.req_valid = 4'b0010;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.uart_write_data !== 1'b0 || bus.busy !== 1'b0) viol++;
    end
    check("bp_hold", 32'(viol), 0);
    bus.uart_tx_status[TX_FULL_BIT] = 1'b0;
    run_txn(0, 8'h5A, 10, nwr, wr_at, bad, rdy_at, rdy, drp, gid);
    check("bp_wr_at", 32'(wr_at), 1);
    check("bp_data_bad", 32'(bad), 0);
    check("bp_rdy_at", 32'(rdy_at), 3);
    check("bp_ready", 32'(rdy), 32'h2);
    bus.req_valid = '0;
    @(negedge clk);

    // error on first attempt, then FIFO full while in RETRY
    bus.req_data  = 32'h0077_0000;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("rf_write1", 32'(bus.uart_write_data), 1);
    bus.uart_tx_status[TX_ERR_BIT] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rf_check_no_ready", 32'(bus.req_ready), 0);
    bus.uart_tx_status[TX_FULL_BIT] = 1'b1;
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.uart_write_data !== 1'b0) viol++;
    end
    check("rf_retry_hold", 32'(viol), 0);
    bus.uart_tx_status[TX_FULL_BIT] = 1'b0;
    bus.uart_tx_status[TX_ERR_BIT]  = 1'b0;
    @(negedge clk);
    check("rf_write2", 32'(bus.uart_write_data), 1);
    check("rf_data2", 32'(bus.uart_bus_data_in), 32'h77);
    run_txn(0, 8'h77, 6, nwr, wr_at, bad, rdy_at, rdy, drp, gid);
    check("rf_rdy_at", 32'(rdy_at), 2);
    check("rf_ready", 32'(rdy), 32'h4);
    check("rf_drop", 32'(drp), 0);
    bus.req_valid = '0;
    @(negedge clk);

    // reset during WAIT, then all four requesting continuously
    bus.req_data  = 32'h1312_1110;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("rst_pre_write", 32'(bus.uart_write_data), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    check("rst_no_ready", 32'(bus.req_ready), 0);
    reset_n = 1'b1;

    nw = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.uart_write_data === 1'b1 && nw < 8) begin
        wr_cyc[nw] = k;
        wr_dat[nw] = bus.uart_bus_data_in;
        nw++;
      end
    end
    check("fair_count", 32'(nw), 5);
    if (nw >= 5) begin
      check("fair_first_at", 32'(wr_cyc[0]), 1);
      for (int i = 0; i < 5; i++) begin
        check($sformatf("fair_data%0d", i), 32'(wr_dat[i]), 32'(8'h10 + 8'(i % 4)));
        if (i > 0) check($sformatf("fair_gap%0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]), 4);
      end
    end
    bus.req_valid = '0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and write sequencer that shares the transmit FIFO write port of one `uart_protocol` instance between `NUM_REQ` requesters. It issues single-cycle `write_data` pulses only when the TX FIFO is not full and checks `error_write_data` after each write. A rejected word is retried a bounded number of times before being dropped. The block sits between on-chip requesters and the UART's `write_data` / `bus_data_in` / `TX_status_register` ports.

## Interface
- `DATA_SIZE`, 8, UART data word width.
- `NUM_REQ`, 4, number of requesters (2..8).
- `RETRY_MAX`, 3, total write attempts per word (1..15).
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  NUM_REQ  per-requester word available; held until matching `req_ready`.
- `req_data`  in  NUM_REQ*DATA_SIZE  flattened words; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- `req_ready`  out  NUM_REQ  one-cycle pulse: word consumed (written or dropped).
- `drop_err`  out  NUM_REQ  one-cycle pulse, coincident with `req_ready`, when the word was dropped after `RETRY_MAX` failures.
- `uart_write_data`  out  1  to UART `write_data`.
- `uart_bus_data_in`  out  DATA_SIZE  to UART `bus_data_in`.
- `uart_tx_status`  in  8  from UART `TX_status_register`: bit0 error_write_data, bit1 full, bit2 empty.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
- States: IDLE, WRITE, WAIT, CHECK, RETRY.
- IDLE: if any `req_valid` and `uart_tx_status[1]==0`, pick the winner round-robin, starting at `last_grant+1` mod NUM_REQ. Latch its index into `grant_id` and its data into the hold register, clear `retry_cnt`, then go to WRITE. Otherwise stay in IDLE.
- WRITE: `uart_write_data=1` for exactly this cycle; `uart_bus_data_in` = hold register. Go to WAIT.
- WAIT: one idle cycle so the UART status register can update. Go to CHECK.
- CHECK: sample `uart_tx_status[0]`.
  - Error clear: pulse `req_ready[grant_id]`, set `last_grant=grant_id`, go to IDLE.
  - Error set and `retry_cnt < RETRY_MAX-1`: increment `retry_cnt`, go to RETRY.
  - Error set and `retry_cnt == RETRY_MAX-1`: pulse `req_ready[grant_id]` and `drop_err[grant_id]`, set `last_grant=grant_id`, go to IDLE.
- RETRY: wait until `uart_tx_status[1]==0`, then go to WRITE with the same hold data. No re-arbitration happens here.
- The requester's data is latched at grant. A requester that deasserts `req_valid` mid-transaction still receives its `req_ready`/`drop_err` pulse.
- `uart_write_data` is never asserted while the `full` bit is sampled high in the deciding cycle (IDLE or RETRY).
- `retry_cnt` width is 4 bits and never exceeds `RETRY_MAX-1`.

## Timing
- Reset values:
  - all outputs 0, including `uart_bus_data_in`, `grant_id`, `busy`, `req_ready`, `drop_err`;
  - state IDLE, `last_grant=NUM_REQ-1`, so requester 0 has first priority;
  - hold register and `retry_cnt` cleared.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Latency, successful case: `req_valid` seen in IDLE at cycle 0, WRITE pulse at cycle 1, WAIT at cycle 2, `req_ready` at cycle 3, back in IDLE at cycle 4.
- Peak throughput is one word per 4 cycles.
- Each retry adds at least 3 cycles (RETRY, WRITE, WAIT) before the next CHECK.
- Full FIFO: IDLE and RETRY hold indefinitely; `busy` stays high in RETRY.
- Simultaneous requests are resolved by the round-robin order only. A requester granted last has the lowest priority next time.
- Asynchronous reset in any state aborts the transaction immediately. No `req_ready` is issued for the aborted word.

## Structure
- Package `uart_ctrl_pkg` holds:
  - the state enum `tx_arb_state_e`;
  - status bit constants `TX_ERR_BIT=0`, `TX_FULL_BIT=1`, `TX_EMPTY_BIT=2`.
- Sub-module `uart_rr_arbiter`: combinational round-robin pick.
  - Inputs: `req[NUM_REQ]` and `last_grant`.
  - Outputs: `any` and `winner`.
- The FSM, hold register and counters live in the top module.

## Test plan
Bench settings: NUM_REQ=4, DATA_SIZE=8, RETRY_MAX=3 unless stated.
- Single request: `req_valid=4'b0100`, data 8'hA5, FIFO not full -> `uart_write_data` one cycle with 8'hA5, `req_ready=4'b0100` exactly 3 cycles after the request, `grant_id=2`.
- Fairness: all four valid continuously with data 8'h10..8'h13 -> writes 8'h10, 8'h11, 8'h12, 8'h13, 8'h10 in that order, each 4 cycles apart.
- Full backpressure: force `uart_tx_status[1]=1` for 20 cycles with `req_valid[1]=1` -> no write and `busy=0` for those cycles; the write occurs 1 cycle after full clears.
- Retry then success: error bit set at the first CHECK only, data 8'h3C -> two write pulses of 8'h3C, `req_ready[0]` with `drop_err=0`.
- Drop: error bit held high, data 8'hFF -> exactly 3 write pulses, then `req_ready[3]` and `drop_err[3]` in the same cycle; the next grant goes to requester 0.
- Reset mid-WAIT: assert `reset_n=0` for 1 cycle -> all outputs 0 immediately, no `req_ready`, and the next grant with all requesters valid goes to requester 0.
